dp_ram_arbiter: RTL and testbench
=================================

Name: dp_ram_arbiter

Overview:
- Two-requester round-robin arbiter that shares the single req/gnt/rvalid port of sp_ram between two masters, for example the instruction and data sides of a core, or two redundant cores.
- Grants one address phase per cycle and forwards the selected address, write-enable and write data.
- Tracks the owner of every outstanding transaction so each rvalid is routed back to the master that issued it.
- Sits directly between the masters and sp_ram.

Parameters:
- ADDR_WIDTH, 32, address width of all address ports
- DATA_WIDTH, 32, data width of all rdata/wdata ports
- MAX_OUTST, 2, maximum granted-but-unanswered transactions (1..4); also the owner-FIFO depth

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- a_req_i  in  1  master A request
- a_gnt_o  out  1  master A grant
- a_rvalid_o  out  1  master A read/write response valid
- a_addr_i  in  ADDR_WIDTH  master A address
- a_we_i  in  1  master A write enable
- a_wdata_i  in  DATA_WIDTH  master A write data
- a_rdata_o  out  DATA_WIDTH  master A read data
- b_req_i, b_gnt_o, b_rvalid_o, b_addr_i, b_we_i, b_wdata_i, b_rdata_o  same as the A ports, for master B
- mem_req_o  out  1  request to sp_ram
- mem_gnt_i  in  1  sp_ram grant
- mem_rvalid_i  in  1  sp_ram response valid
- mem_addr_o  out  ADDR_WIDTH  address to sp_ram
- mem_we_o  out  1  write enable to sp_ram
- mem_wdata_o  out  DATA_WIDTH  write data to sp_ram
- mem_rdata_i  in  DATA_WIDTH  read data from sp_ram
- err_o  out  1  sticky protocol error: rvalid received with no outstanding transaction

Behaviour:
- Reset: one clock, synchronous, active-low.
  - On the reset edge: outstanding count=0, owner FIFO pointers=0, last_grant=B (so A wins the first conflict), lock=0, err_o=0.
  - While rst_n=0, all gnt/rvalid/mem_req_o outputs are forced to 0.
- full = (count==MAX_OUTST).
  - mem_req_o = (a_req_i | b_req_i) & !full.
  - When full, no grant is issued, even if mem_rvalid_i is high in the same cycle. A grant resumes the next cycle.
- Selection:
  - Only one master requesting: that master is selected.
  - Both requesting: the master that did not win last_grant is selected.
  - mem_addr_o, mem_we_o and mem_wdata_o are combinationally muxed from the selected master. When mem_req_o=0 they are driven to 0.
- Lock:
  - If mem_req_o=1 and mem_gnt_i=0, selection is registered and held (lock=1) until the handshake.
  - Request content stays stable toward sp_ram; the other master cannot preempt.
  - lock clears on the handshake cycle.
- Handshake = mem_req_o & mem_gnt_i.
  - The selected master's gnt_o = mem_gnt_i in the same cycle, so grant latency is 0 beyond sp_ram's.
  - The unselected gnt_o = 0.
  - On a handshake, last_grant <= selected and the owner bit is pushed into the FIFO.
- Masters hold req/addr/we/wdata stable from req assertion until gnt.
- Response:
  - On mem_rvalid_i with count>0: pop the FIFO head and assert rvalid_o of the head owner only, in the same cycle.
  - a_rdata_o and b_rdata_o both equal mem_rdata_i at all times.
  - Responses are in order. Write responses also produce rvalid.
- Count update:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop in the same cycle: count unchanged; the FIFO head advances and the tail writes.
  - Pointers wrap modulo MAX_OUTST.
- mem_rvalid_i with count==0: no rvalid_o asserted, count stays 0, err_o <= 1 (sticky until reset).
- Reset mid-operation drops all outstanding tracking. sp_ram is reset on the same rst_n, so no stale responses are permitted.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: round robin is replaced by fixed priority. Master A always wins a conflict; last_grant is not implemented. Lock behaviour is unchanged.
- Undefined: round robin as described above.

Test Plan:
- Single master: A writes 0xDEADBEEF to addr 0x10, then reads addr 0x10 -> a_gnt_o=1 in each request cycle, two a_rvalid_o pulses one cycle after each grant, a_rdata_o=0xDEADBEEF, b_rvalid_o never asserted.
- Continuous conflict: A and B both request reads every cycle for 6 cycles -> grants alternate A,B,A,B,A,B, starting with A after reset; rvalids follow the same order.
- Lock under stall: mem_gnt_i held 0 for 3 cycles while A is selected and B raises req in cycle 1 -> mem_addr_o stays A's address all 3 cycles; A granted first, B granted next.
- Full: MAX_OUTST=2, mem_rvalid_i held 0, A and B requesting -> exactly 2 handshakes, then mem_req_o=0. Single rvalid -> one new grant follows the next cycle.
- Spurious response: mem_rvalid_i pulsed with count=0 -> err_o=1 from the next cycle and stays set; no rvalid_o; err_o cleared by rst_n low for one edge.
- With ARB_FIXED_PRIO_EN defined: continuous A+B conflict for 4 cycles -> all 4 grants to A, B granted only after a_req_i drops.

Source files
------------

// File: rtl/dp_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dp_ram_arbiter
// Description : Two-master round-robin arbiter in front of a single sp_ram
//               req/gnt/rvalid port, with in-order response routing.
//               Define ARB_FIXED_PRIO_EN for fixed priority (master A wins).
// Revision    : 1.0 - initial release
// ============================================================================
module dp_ram_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTST  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  a_req_i,
  output logic                  a_gnt_o,
  output logic                  a_rvalid_o,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic                  a_we_i,
  input  logic [DATA_WIDTH-1:0] a_wdata_i,
  output logic [DATA_WIDTH-1:0] a_rdata_o,

  input  logic                  b_req_i,
  output logic                  b_gnt_o,
  output logic                  b_rvalid_o,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic                  b_we_i,
  input  logic [DATA_WIDTH-1:0] b_wdata_i,
  output logic [DATA_WIDTH-1:0] b_rdata_o,

  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,

  output logic                  err_o
);

  localparam int c_cnt_w = $clog2(MAX_OUTST + 1);
  localparam int c_ptr_w = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(MAX_OUTST);
  localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(MAX_OUTST - 1);

  logic [c_cnt_w-1:0]   r_count;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [MAX_OUTST-1:0] r_owner_b;
  logic                 r_lock;
  logic                 r_lock_sel_b;
  logic                 r_err;
`ifndef ARB_FIXED_PRIO_EN
  logic                 r_last_b;
`endif

  logic w_full;
  logic w_any_req;
  logic w_mem_req;
  logic w_sel_b;
  logic w_hs;
  logic w_pop;
  logic w_spurious;
  logic w_head_b;

  function automatic logic [c_ptr_w-1:0] f_next_ptr(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_last) ? '0 : p + 1'b1;
  endfunction

  assign w_full     = (r_count == c_full_cnt);
  assign w_any_req  = a_req_i | b_req_i;
  assign w_mem_req  = rst_n & w_any_req & ~w_full;
  assign w_hs       = w_mem_req & mem_gnt_i;
  assign w_pop      = rst_n & mem_rvalid_i & (r_count != '0);
  assign w_spurious = mem_rvalid_i & (r_count == '0);
  assign w_head_b   = r_owner_b[r_rd_ptr];

  // A stalled request keeps its owner until sp_ram accepts it.
  always_comb begin
    w_sel_b = 1'b0;
    if (r_lock) begin
      w_sel_b = r_lock_sel_b;
    end else if (a_req_i && b_req_i) begin
`ifdef ARB_FIXED_PRIO_EN
      w_sel_b = 1'b0;
`else
      w_sel_b = ~r_last_b;
`endif
    end else begin
      w_sel_b = b_req_i;
    end
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    if (w_mem_req) begin
      if (w_sel_b) begin
        mem_addr_o  = b_addr_i;
        mem_we_o    = b_we_i;
        mem_wdata_o = b_wdata_i;
      end else begin
        mem_addr_o  = a_addr_i;
        mem_we_o    = a_we_i;
        mem_wdata_o = a_wdata_i;
      end
    end
  end

  assign mem_req_o  = w_mem_req;
  assign a_gnt_o    = w_hs & ~w_sel_b;
  assign b_gnt_o    = w_hs &  w_sel_b;
  assign a_rvalid_o = w_pop & ~w_head_b;
  assign b_rvalid_o = w_pop &  w_head_b;
  assign a_rdata_o  = mem_rdata_i;
  assign b_rdata_o  = mem_rdata_i;
  assign err_o      = r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_owner_b    <= '0;
      r_lock       <= 1'b0;
      r_lock_sel_b <= 1'b0;
      r_err        <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      r_last_b     <= 1'b1;
`endif
    end else begin
      if (w_hs) begin
        r_owner_b[r_wr_ptr] <= w_sel_b;
        r_wr_ptr            <= f_next_ptr(r_wr_ptr);
        r_lock              <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
        r_last_b            <= w_sel_b;
`endif
      end else if (w_mem_req) begin
        r_lock       <= 1'b1;
        r_lock_sel_b <= w_sel_b;
      end

      if (w_pop) begin
        r_rd_ptr <= f_next_ptr(r_rd_ptr);
      end

      case ({w_hs, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_spurious) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dp_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dp_ram_arbiter
// Description : Directed and randomized bench for dp_ram_arbiter with an
//               abstract arbiter/sp_ram reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_ram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req_i, a_gnt_o, a_rvalid_o, a_we_i;
  logic [AW-1:0] a_addr_i;
  logic [DW-1:0] a_wdata_i, a_rdata_o;
  logic          b_req_i, b_gnt_o, b_rvalid_o, b_we_i;
  logic [AW-1:0] b_addr_i;
  logic [DW-1:0] b_wdata_i, b_rdata_o;
  logic          mem_req_o, mem_gnt_i, mem_rvalid_i, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;
  logic          err_o;

  always #5 clk = ~clk;

  dp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(MO)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_i(a_req_i), .a_gnt_o(a_gnt_o), .a_rvalid_o(a_rvalid_o),
    .a_addr_i(a_addr_i), .a_we_i(a_we_i), .a_wdata_i(a_wdata_i), .a_rdata_o(a_rdata_o),
    .b_req_i(b_req_i), .b_gnt_o(b_gnt_o), .b_rvalid_o(b_rvalid_o),
    .b_addr_i(b_addr_i), .b_we_i(b_we_i), .b_wdata_i(b_wdata_i), .b_rdata_o(b_rdata_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;

  // reference model: owner queue, sp_ram contents and pending responses
  int          own_q[$];
  logic [31:0] pend[$];
  logic [31:0] mem[256];
  int          last_w;
  bit          lock_v;
  int          lock_s;
  bit          err_m;
  int          rsp_mode;
  bit          spurious;

  int          gnt_log[$];
  int          rv_log[$];
  int          a_rv_cnt, b_rv_cnt;
  logic [31:0] a_last_rd;
  logic [31:0] obs_addr;
  logic        obs_req, obs_ga, obs_gb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    rv_log.delete();
    a_rv_cnt = 0;
    b_rv_cnt = 0;
  endtask

  task automatic cycle();
    int          cnt, sel, head;
    bit          e_req, hs, pop;
    logic [31:0] e_addr, e_wd;
    logic        e_we;
    case (rsp_mode)
      1:       mem_rvalid_i = (pend.size() > 0);
      2:       mem_rvalid_i = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
      default: mem_rvalid_i = 1'b0;
    endcase
    if (spurious) mem_rvalid_i = 1'b1;
    mem_rdata_i = (pend.size() > 0) ? pend[0] : 32'($urandom);
    #1;
    cnt   = own_q.size();
    head  = (cnt > 0) ? own_q[0] : -1;
    e_req = (rst_n === 1'b1) && (a_req_i || b_req_i) && (cnt < MO);
    if (lock_v) sel = lock_s;
    else if (a_req_i && b_req_i) begin
`ifdef ARB_FIXED_PRIO_EN
      sel = 0;
`else
      sel = (last_w == 0) ? 1 : 0;
`endif
    end else sel = b_req_i ? 1 : 0;
    e_addr = e_req ? ((sel == 1) ? b_addr_i : a_addr_i) : 32'h0;
    e_we   = e_req ? ((sel == 1) ? b_we_i : a_we_i) : 1'b0;
    e_wd   = e_req ? ((sel == 1) ? b_wdata_i : a_wdata_i) : 32'h0;
    hs     = e_req && mem_gnt_i;
    pop    = (rst_n === 1'b1) && mem_rvalid_i && (cnt > 0);

    chk("mem_req", mem_req_o, e_req);
    chk("mem_addr", mem_addr_o, e_addr);
    chk("mem_we", mem_we_o, e_we);
    chk("mem_wdata", mem_wdata_o, e_wd);
    chk("a_gnt", a_gnt_o, hs && sel == 0);
    chk("b_gnt", b_gnt_o, hs && sel == 1);
    chk("a_rvalid", a_rvalid_o, pop && head == 0);
    chk("b_rvalid", b_rvalid_o, pop && head == 1);
    chk("err", err_o, err_m);
    chk("a_rdata", a_rdata_o, mem_rdata_i);
    chk("b_rdata", b_rdata_o, mem_rdata_i);

    if (a_gnt_o) gnt_log.push_back(0);
    if (b_gnt_o) gnt_log.push_back(1);
    if (a_rvalid_o) begin rv_log.push_back(0); a_rv_cnt++; a_last_rd = a_rdata_o; end
    if (b_rvalid_o) begin rv_log.push_back(1); b_rv_cnt++; end
    obs_addr = mem_addr_o;
    obs_req  = mem_req_o;
    obs_ga   = a_gnt_o;
    obs_gb   = b_gnt_o;

    @(posedge clk);
    if (rst_n !== 1'b1) begin
      own_q.delete();
      pend.delete();
      last_w = 1;
      lock_v = 0;
      err_m  = 0;
    end else begin
      if (mem_rvalid_i && cnt == 0) err_m = 1;
      if (pop) begin
        void'(own_q.pop_front());
        void'(pend.pop_front());
      end
      if (hs) begin
        own_q.push_back(sel);
        last_w = sel;
        lock_v = 0;
        if (e_we) begin
          mem[e_addr[7:0]] = e_wd;
          pend.push_back(32'h0);
        end else begin
          pend.push_back(mem[e_addr[7:0]]);
        end
      end else if (e_req) begin
        lock_v = 1;
        lock_s = sel;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    a_req_i  = 1'b0;
    b_req_i  = 1'b0;
    rsp_mode = 1;
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    bit a_hold, b_hold;
    rst_n = 1'b0;
    a_req_i = 1'b1; a_we_i = 1'b0; a_addr_i = '0; a_wdata_i = '0;
    b_req_i = 1'b1; b_we_i = 1'b0; b_addr_i = '0; b_wdata_i = '0;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    last_w = 1; lock_v = 0; lock_s = 0; err_m = 0;
    rsp_mode = 0; spurious = 0;
    clear_logs();
    repeat (2) @(posedge clk);
    #1;

    // reset holds outputs low even with requests and a response present
    spurious = 1;
    cycle();
    spurious = 0;
    rst_n = 1'b1;
    a_req_i = 1'b0;
    b_req_i = 1'b0;
    idle(1);

    // single master write then read
    clear_logs();
    rsp_mode = 1;
    mem_gnt_i = 1'b1;
    a_req_i = 1'b1; a_we_i = 1'b1; a_addr_i = 32'h10; a_wdata_i = 32'hDEADBEEF;
    cycle();
    a_we_i = 1'b0; a_wdata_i = 32'h0;
    cycle();
    idle(3);
    chk("single_gnts", gnt_log.size(), 2);
    chk("single_rv", a_rv_cnt, 2);
    chk("single_brv", b_rv_cnt, 0);
    chk("single_rdata", a_last_rd, 32'hDEADBEEF);

`ifndef ARB_FIXED_PRIO_EN
    // round robin from reset under continuous conflict
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    clear_logs();
    a_req_i = 1'b1; a_we_i = 1'b0; a_addr_i = 32'h20;
    b_req_i = 1'b1; b_we_i = 1'b0; b_addr_i = 32'h30;
    for (int k = 0; k < 6; k++) cycle();
    idle(3);
    chk("rr_count", gnt_log.size(), 6);
    chk("rr_rvcount", rv_log.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < gnt_log.size()) chk("rr_gnt", gnt_log[k], k % 2);
      if (k < rv_log.size())  chk("rr_rv", rv_log[k], k % 2);
    end
`endif

    // lock: give A the last grant, then stall A while B arrives
    a_req_i = 1'b1; a_addr_i = 32'h44;
    cycle();
    a_req_i = 1'b0;
    idle(2);
    clear_logs();
    mem_gnt_i = 1'b0;
    a_req_i = 1'b1; a_addr_i = 32'h40;
    cycle();
    chk("lock_addr0", obs_addr, 32'h40);
    b_req_i = 1'b1; b_addr_i = 32'h50;
    cycle();
    chk("lock_addr1", obs_addr, 32'h40);
    cycle();
    chk("lock_addr2", obs_addr, 32'h40);
    mem_gnt_i = 1'b1;
    cycle();
    a_req_i = 1'b0;
    cycle();
    idle(3);
    chk("lock_cnt", gnt_log.size(), 2);
    if (gnt_log.size() >= 2) begin
      chk("lock_first", gnt_log[0], 0);
      chk("lock_second", gnt_log[1], 1);
    end

    // full: no responses, both masters requesting
    clear_logs();
    rsp_mode = 0;
    a_req_i = 1'b1; a_addr_i = 32'h11;
    b_req_i = 1'b1; b_addr_i = 32'h12;
    for (int k = 0; k < 4; k++) cycle();
    chk("full_hs", gnt_log.size(), 2);
    chk("full_req", obs_req, 1'b0);
    rsp_mode = 1;
    cycle();
    chk("full_rv_nogrant", obs_req, 1'b0);
    rsp_mode = 0;
    cycle();
    chk("full_resume", gnt_log.size(), 3);
    cycle();
    chk("full_again", gnt_log.size(), 3);
    idle(5);

    // spurious response
    clear_logs();
    spurious = 1;
    cycle();
    spurious = 0;
    chk("spur_no_rv", a_rv_cnt + b_rv_cnt, 0);
    chk("spur_err", err_o, 1'b1);
    cycle();
    chk("spur_sticky", err_o, 1'b1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("spur_clear", err_o, 1'b0);

`ifdef ARB_FIXED_PRIO_EN
    clear_logs();
    a_req_i = 1'b1; a_addr_i = 32'h20;
    b_req_i = 1'b1; b_addr_i = 32'h30;
    for (int k = 0; k < 4; k++) cycle();
    chk("fp_count", gnt_log.size(), 4);
    for (int k = 0; k < 4; k++) if (k < gnt_log.size()) chk("fp_gnt", gnt_log[k], 0);
    a_req_i = 1'b0;
    cycle();
    chk("fp_b", gnt_log.size() == 5 && gnt_log[gnt_log.size()-1] == 1, 1'b1);
    idle(3);
`endif

    // randomized traffic
    rsp_mode = 2;
    a_req_i = 1'b0; b_req_i = 1'b0;
    a_hold = 0; b_hold = 0;
    for (int k = 0; k < 400; k++) begin
      mem_gnt_i = ($urandom_range(0, 3) != 0);
      cycle();
      if (obs_ga) a_hold = 0;
      if (obs_gb) b_hold = 0;
      if (!a_hold) begin
        a_req_i = ($urandom_range(0, 2) != 0);
        if (a_req_i) begin
          a_hold = 1; a_we_i = $urandom_range(0, 1) == 1;
          a_addr_i = 32'($urandom_range(0, 15)); a_wdata_i = 32'($urandom);
        end
      end
      if (!b_hold) begin
        b_req_i = ($urandom_range(0, 2) != 0);
        if (b_req_i) begin
          b_hold = 1; b_we_i = $urandom_range(0, 1) == 1;
          b_addr_i = 32'($urandom_range(0, 15)); b_wdata_i = 32'($urandom);
        end
      end
    end
    idle(6);
    chk("drained_err", err_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
